axis_fifo_pkt: RTL and testbench
================================

// Module: axis_fifo_pkt
// PURPOSE
//  Parametrised AXI-Stream FIFO, successor to the basic tdata/tlast stream FIFO. Adds tkeep/tuser
//  sideband, all 2**ADDR_WIDTH entries usable, fill level and almost-full/almost-empty flags, and
//  an optional store-and-forward packet mode. Sits between stream producers and consumers
//  (DMA, framers, packet parsers) on a single clock domain.
// PARAMETERS
//  DATA_WIDTH   8   tdata width in bits (multiple of 8)
//  USER_WIDTH   1   tuser width in bits (>=1)
//  ADDR_WIDTH   4   log2 of depth; DEPTH = 2**ADDR_WIDTH entries
//  PACKET_MODE  0   0 = cut-through, 1 = store-and-forward on tlast
//  AF_LEVEL     12  almost_full when fill_level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL     2   almost_empty when fill_level <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  aclk           in   1              clock, all logic on rising edge
//  aresetn        in   1              synchronous active-low reset
//  s_axis_tdata   in   DATA_WIDTH     input data
//  s_axis_tkeep   in   DATA_WIDTH/8   input byte enables, stored unmodified
//  s_axis_tuser   in   USER_WIDTH     input sideband, stored unmodified
//  s_axis_tlast   in   1              input end of packet
//  s_axis_tvalid  in   1              input beat valid
//  s_axis_tready  out  1              FIFO can accept a beat
//  m_axis_tdata   out  DATA_WIDTH     output data
//  m_axis_tkeep   out  DATA_WIDTH/8   output byte enables
//  m_axis_tuser   out  USER_WIDTH     output sideband
//  m_axis_tlast   out  1              output end of packet
//  m_axis_tvalid  out  1              output beat valid
//  m_axis_tready  in   1              downstream accepts beat
//  fill_level     out  ADDR_WIDTH+1   beats currently held (0..DEPTH)
//  almost_full    out  1              fill_level >= AF_LEVEL
//  almost_empty   out  1              fill_level <= AE_LEVEL
//  oversize       out  1              one-cycle pulse: packet-mode fallback entered
// BEHAVIOUR
//  - Reset (aresetn=0 at an edge): pointers, fill_level, packet count cleared; s_axis_tready=0,
//    m_axis_tvalid=0, almost_full=0, almost_empty=1, oversize=0. Memory contents not cleared.
//  - s_axis_tready is 0 while aresetn=0 and in the first cycle after release; thereafter
//    s_axis_tready = (fill_level < DEPTH). No dependence on m_axis_tready (no full-pass-through).
//  - Push on s_axis_tvalid&&s_axis_tready; pop on m_axis_tvalid&&m_axis_tready.
//    fill_level: +1 push only, -1 pop only, unchanged on both. Never exceeds DEPTH or underflows.
//  - Pointers ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH; empty = equal, full = MSB differ, rest equal.
//  - Latency: beat pushed at edge N is valid on m_axis from edge N+1 (cut-through). Output order =
//    input order; tdata/tkeep/tuser/tlast travel together.
//  - m_axis_* payload held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
//    m_axis_tvalid never deasserts without a pop (except reset).
//  - PACKET_MODE=1: pkt_count = complete packets stored (+1 on push with tlast, -1 on pop with
//    tlast, unchanged on both). m_axis_tvalid = (fill_level>0) && (pkt_count>0 || fallback).
//  - Fallback (packet mode): if fill_level==DEPTH and pkt_count==0, set fallback and pulse oversize
//    for one cycle; output streams in cut-through until the pop of a tlast beat clears fallback.
//  - almost_full/almost_empty are registered from next fill_level, so coherent with fill_level.
//  - Reset mid-packet discards all content; first beat after reset starts a new packet.
// TESTING
//  1. Cut-through, DEPTH=16: push 0x01..0x10, m_axis_tready=0 -> fill_level=16, tready=0 after
//     16th, almost_full from 12th; then drain -> 0x01..0x10 in order, tlast/tkeep/tuser intact.
//  2. Empty FIFO, push 0xA5 at edge N -> m_axis_tvalid=1, tdata=0xA5 at N+1; pop -> fill_level 0.
//  3. Simultaneous push/pop every cycle at fill_level=5 for 40 beats (pointers wrap twice)
//     -> fill_level stays 5, no loss, no reordering.
//  4. PACKET_MODE=1: push 3-beat packet with 1-cycle gaps -> m_axis_tvalid=0 until tlast beat
//     pushed, then 3 beats delivered back-to-back with m_axis_tready=1.
//  5. PACKET_MODE=1: push 20-beat packet -> at fill 16 oversize pulses once, output streams,
//     all 20 beats delivered in order, fallback cleared after tlast pop.
//  6. Reset (aresetn=0 one cycle) with fill_level=7 mid-packet, random m_axis_tready
//     -> next cycle fill_level=0, m_axis_tvalid=0, s_axis_tready=0 then 1 one cycle later.

Source files
------------

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with tkeep/tuser sideband, fill level, almost-full/empty flags
// and optional store-and-forward packet mode with an oversize-packet fallback.
// Storage is an array with a registered read port. The read address is the
// next-state read pointer, and a same-address write is bypassed. As a result the
// output register always holds the entry at the head of the FIFO.
module axis_fifo_pkt #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 4,
  parameter int PACKET_MODE = 0,
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [ADDR_WIDTH:0]     fill_level,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    oversize
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PW         = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO    = '0;

  // Payload storage; the contents are deliberately left untouched by reset.
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_data_q;
  logic [PW-1:0] in_payload;

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] fill_q, fill_d;
  logic [ADDR_WIDTH:0] pkt_count_q, pkt_count_d;
  logic                ready_en_q;
  logic                fallback_q, fallback_d;
  logic                oversize_q, oversize_d;
  logic                almost_full_q, almost_empty_q;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  full;
  logic                  empty;
  logic                  pkt_gate;
  logic                  push;
  logic                  pop;

  assign in_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = rd_data_q;

  assign wr_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr_d = rd_ptr_d[ADDR_WIDTH-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  // In cut-through mode every stored beat is eligible for output. In packet
  // mode a beat is released only when a whole packet is stored, or while a
  // packet too large for the FIFO is being streamed through.
  assign pkt_gate = (PACKET_MODE == 0) || (pkt_count_q != ZERO) || fallback_q;

  // The ready signal is held low during reset and in the first cycle after
  // release. It never looks at m_axis_tready.
  assign s_axis_tready = aresetn && ready_en_q && !full;
  assign m_axis_tvalid = !empty && pkt_gate;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign fill_level   = fill_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign oversize     = oversize_q;

  // Next-state logic for the pointers, the counters and the fallback state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (ADDR_WIDTH+1)'(push);
    rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH+1)'(pop);
    fill_d      = fill_q;
    pkt_count_d = pkt_count_q;
    fallback_d  = fallback_q;
    oversize_d  = 1'b0;

    case ({push, pop})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase

    case ({push && s_axis_tlast, pop && m_axis_tlast})
      2'b10:   pkt_count_d = pkt_count_q + ONE;
      2'b01:   pkt_count_d = pkt_count_q - ONE;
      default: pkt_count_d = pkt_count_q;
    endcase

    // Enter fallback when the FIFO is full but holds no complete packet, because
    // this packet can never fit. Leave fallback when its last beat is popped.
    if (PACKET_MODE != 0) begin
      if (!fallback_q && (fill_q == DEPTH_L) && (pkt_count_q == ZERO)) begin
        fallback_d = 1'b1;
        oversize_d = 1'b1;
      end else if (fallback_q && pop && m_axis_tlast) begin
        fallback_d = 1'b0;
      end
    end
  end

  // State registers and the flags derived from the next fill level.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fill_q         <= '0;
      pkt_count_q    <= '0;
      ready_en_q     <= 1'b0;
      fallback_q     <= 1'b0;
      oversize_q     <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fill_q         <= fill_d;
      pkt_count_q    <= pkt_count_d;
      ready_en_q     <= 1'b1;
      fallback_q     <= fallback_d;
      oversize_q     <= oversize_d;
      almost_full_q  <= (fill_d >= AF_L);
      almost_empty_q <= (fill_d <= AE_L);
    end
  end

  // Memory write port.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_addr] <= in_payload;
    end
  end

  // Registered read of the next head entry. A same-cycle write to that address
  // is forwarded, so a beat pushed into an empty FIFO appears one cycle later.
  always_ff @(posedge aclk) begin
    if (push && (wr_addr == rd_addr_d)) begin
      rd_data_q <= in_payload;
    end else begin
      rd_data_q <= mem[rd_addr_d];
    end
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed bench for axis_fifo_pkt. It uses a cut-through instance (index 0)
// and a packet-mode instance (index 1). Accepted input beats go into a
// per-instance expected queue, and a separate monitor pops and compares every
// delivered beat.
module tb_axis_fifo_pkt;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic            aresetn;
  logic [1:0][7:0] s_tdata;
  logic [1:0]      s_tkeep, s_tuser, s_tlast, s_tvalid;
  wire  [1:0]      s_tready;
  wire  [1:0][7:0] m_tdata;
  wire  [1:0]      m_tkeep, m_tuser, m_tlast, m_tvalid;
  logic [1:0]      m_tready;
  wire  [1:0][4:0] fill;
  wire  [1:0]      af, ae, osz;

  int checks = 0;
  int errors = 0;
  int osz_cnt0 = 0;
  int osz_cnt1 = 0;

  logic [10:0] exp0 [$];
  logic [10:0] exp1 [$];

  axis_fifo_pkt #(.PACKET_MODE(0)) u_ct (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tuser(s_tuser[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .fill_level(fill[0]), .almost_full(af[0]), .almost_empty(ae[0]), .oversize(osz[0])
  );

  axis_fifo_pkt #(.PACKET_MODE(1)) u_pk (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tuser(s_tuser[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .fill_level(fill[1]), .almost_full(af[1]), .almost_empty(ae[1]), .oversize(osz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance and record the expectation.
  // The task is entered and left 1 ns after a rising edge.
  task automatic push_beat(input int d, input logic [7:0] data, input logic keep,
                           input logic user, input logic last);
    int n;
    n = 0;
    s_tdata[d]  = data;
    s_tkeep[d]  = keep;
    s_tuser[d]  = user;
    s_tlast[d]  = last;
    s_tvalid[d] = 1'b1;
    @(negedge aclk);
    while (!s_tready[d] && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (!s_tready[d]) begin
      checks++;
      errors++;
      $display("FAIL push_timeout dut%0d: tready got 0 expected 1", d);
    end else if (d == 0) begin
      exp0.push_back({data, keep, user, last});
    end else begin
      exp1.push_back({data, keep, user, last});
    end
    @(posedge aclk);
    #1;
    s_tvalid[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (fill[d] != 5'd0 && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk($sformatf("drain_dut%0d", d), 32'(fill[d]), 0);
  endtask

  // Monitor: compare every delivered beat and check that a stalled output is held.
  logic [10:0] mon_pay, mon_exp;
  logic [1:0]  prev_stall = 2'b00;
  logic [10:0] prev_pay [2];
  logic        prev_rstn = 1'b0;
  initial begin
    forever begin
      @(negedge aclk);
      for (int d = 0; d < 2; d++) begin
        mon_pay = {m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d]};
        if (prev_stall[d] && prev_rstn && aresetn) begin
          chk($sformatf("hold_valid_dut%0d", d), 32'(m_tvalid[d]), 1);
          chk($sformatf("hold_payload_dut%0d", d), 32'(mon_pay), 32'(prev_pay[d]));
        end
        if (m_tvalid[d] && m_tready[d]) begin
          if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat_dut%0d: got 0x%0h expected no beat", d, mon_pay);
          end else begin
            if (d == 0) mon_exp = exp0.pop_front();
            else        mon_exp = exp1.pop_front();
            $display("dut%0d pop tdata=%02h keep=%b user=%b last=%b", d,
                     m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d]);
            chk($sformatf("beat_dut%0d", d), 32'(mon_pay), 32'(mon_exp));
          end
        end
        prev_stall[d] = m_tvalid[d] && !m_tready[d];
        prev_pay[d]   = mon_pay;
      end
      prev_rstn = aresetn;
      if (osz[0]) osz_cnt0++;
      if (osz[1]) osz_cnt1++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tlast  = '0;
    s_tvalid = '0;
    m_tready = '0;
    cyc(3);

    // Reset state
    chk("rst_tready", 32'(s_tready[0]), 0);
    chk("rst_tvalid", 32'(m_tvalid[0]), 0);
    chk("rst_fill", 32'(fill[0]), 0);
    chk("rst_af", 32'(af[0]), 0);
    chk("rst_ae", 32'(ae[0]), 1);
    chk("rst_osz", 32'(osz[1]), 0);
    chk("rst_tvalid_pk", 32'(m_tvalid[1]), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_first_cycle", 32'(s_tready[0]), 0);
    cyc(1);
    chk("tready_after_release", 32'(s_tready[0]), 1);

    // 1: fill to 16 with output stalled, then drain in order
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] v;
      v = 8'(i);
      push_beat(0, v, v[1], v[0], (i % 4) == 0);
      chk($sformatf("t1_fill_%0d", i), 32'(fill[0]), 32'(i));
      chk($sformatf("t1_af_%0d", i), 32'(af[0]), 32'(i >= 12));
      chk($sformatf("t1_ae_%0d", i), 32'(ae[0]), 32'(i <= 2));
    end
    chk("t1_tready_full", 32'(s_tready[0]), 0);
    chk("t1_tvalid_full", 32'(m_tvalid[0]), 1);
    m_tready[0] = 1'b1;
    wait_drain(0);
    chk("t1_af_empty", 32'(af[0]), 0);
    chk("t1_ae_empty", 32'(ae[0]), 1);
    m_tready[0] = 1'b0;
    cyc(1);

    // 2: single-beat latency
    chk("t2_tvalid_before", 32'(m_tvalid[0]), 0);
    push_beat(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    chk("t2_tvalid_n1", 32'(m_tvalid[0]), 1);
    chk("t2_tdata_n1", 32'(m_tdata[0]), 32'h0A5);
    chk("t2_fill_n1", 32'(fill[0]), 1);
    m_tready[0] = 1'b1;
    cyc(1);
    chk("t2_fill_after_pop", 32'(fill[0]), 0);
    chk("t2_tvalid_after_pop", 32'(m_tvalid[0]), 0);
    m_tready[0] = 1'b0;

    // 3: simultaneous push/pop at level 5 for 40 beats
    for (int i = 0; i < 45; i++) begin
      logic [7:0] v;
      v = 8'h20 + 8'(i);
      if (i == 5) m_tready[0] = 1'b1;
      push_beat(0, v, v[1], v[0], (i % 7) == 6);
      if (i >= 5) chk($sformatf("t3_fill_%0d", i), 32'(fill[0]), 5);
    end
    wait_drain(0);
    m_tready[0] = 1'b0;

    // 4: packet mode, 3-beat packet pushed with gaps
    m_tready[1] = 1'b1;
    push_beat(1, 8'hB0, 1'b1, 1'b0, 1'b0);
    chk("t4_tvalid_b0", 32'(m_tvalid[1]), 0);
    cyc(1);
    chk("t4_tvalid_gap0", 32'(m_tvalid[1]), 0);
    push_beat(1, 8'hB1, 1'b0, 1'b1, 1'b0);
    chk("t4_tvalid_b1", 32'(m_tvalid[1]), 0);
    cyc(1);
    chk("t4_tvalid_gap1", 32'(m_tvalid[1]), 0);
    push_beat(1, 8'hB2, 1'b1, 1'b1, 1'b1);
    chk("t4_tvalid_last", 32'(m_tvalid[1]), 1);
    chk("t4_fill_3", 32'(fill[1]), 3);
    cyc(1);
    chk("t4_tvalid_2", 32'(m_tvalid[1]), 1);
    chk("t4_fill_2", 32'(fill[1]), 2);
    cyc(1);
    chk("t4_tvalid_1", 32'(m_tvalid[1]), 1);
    chk("t4_fill_1", 32'(fill[1]), 1);
    cyc(1);
    chk("t4_tvalid_0", 32'(m_tvalid[1]), 0);
    chk("t4_fill_0", 32'(fill[1]), 0);

    // 5: oversize packet of 20 beats
    m_tready[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = 8'h40 + 8'(i);
      push_beat(1, v, v[1], v[0], 1'b0);
    end
    chk("t5_fill_full", 32'(fill[1]), 16);
    chk("t5_tvalid_full", 32'(m_tvalid[1]), 0);
    chk("t5_osz_before", 32'(osz[1]), 0);
    cyc(1);
    chk("t5_osz_pulse", 32'(osz[1]), 1);
    chk("t5_tvalid_fallback", 32'(m_tvalid[1]), 1);
    cyc(1);
    chk("t5_osz_after", 32'(osz[1]), 0);
    m_tready[1] = 1'b1;
    for (int i = 16; i < 20; i++) begin
      logic [7:0] v;
      v = 8'h40 + 8'(i);
      push_beat(1, v, v[1], v[0], i == 19);
    end
    wait_drain(1);
    chk("t5_osz_count", 32'(osz_cnt1), 1);
    push_beat(1, 8'h60, 1'b0, 1'b0, 1'b0);
    chk("t5_fallback_cleared", 32'(m_tvalid[1]), 0);
    cyc(1);
    chk("t5_fallback_cleared2", 32'(m_tvalid[1]), 0);
    push_beat(1, 8'h61, 1'b1, 1'b0, 1'b1);
    wait_drain(1);

    // 6: reset with 7 beats of an unfinished packet stored
    for (int i = 0; i < 7; i++) begin
      logic [7:0] v;
      v = 8'h70 + 8'(i);
      m_tready[1] = 1'($urandom_range(0, 1));
      push_beat(1, v, v[1], v[0], 1'b0);
    end
    chk("t6_fill_7", 32'(fill[1]), 7);
    chk("t6_tvalid_partial", 32'(m_tvalid[1]), 0);
    aresetn = 1'b0;
    #1;
    chk("t6_tready_in_reset", 32'(s_tready[1]), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp0.delete();
    exp1.delete();
    chk("t6_fill_after", 32'(fill[1]), 0);
    chk("t6_tvalid_after", 32'(m_tvalid[1]), 0);
    chk("t6_tready_after", 32'(s_tready[1]), 0);
    chk("t6_ae_after", 32'(ae[1]), 1);
    chk("t6_af_after", 32'(af[1]), 0);
    cyc(1);
    chk("t6_tready_later", 32'(s_tready[1]), 1);
    m_tready[1] = 1'b1;
    push_beat(1, 8'h77, 1'b1, 1'b1, 1'b1);
    chk("t6_new_packet_valid", 32'(m_tvalid[1]), 1);
    wait_drain(1);

    cyc(3);
    chk("end_sb0_empty", 32'(exp0.size()), 0);
    chk("end_sb1_empty", 32'(exp1.size()), 0);
    chk("end_osz_ct", 32'(osz_cnt0), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
